// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port register file with optional WB-to-ID bypass and a per-register
// pending-write scoreboard. Register 0 reads as zero and is never busy.
module regfile_mp_scoreboard #(
  parameter int unsigned N      = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_read_reg,
  output logic [NUM_RD*N-1:0]      o_read_data,
  output logic [NUM_RD-1:0]        o_read_busy,
  input  logic                     i_reg_write,
  input  logic [ADDR_W-1:0]        i_write_reg,
  input  logic [N-1:0]             i_write_data,
  input  logic                     i_issue_valid,
  input  logic [ADDR_W-1:0]        i_issue_reg,
  input  logic                     i_flush,
  output logic                     o_any_busy
);

  logic [N-1:0]     w_regs [DEPTH];
  logic [DEPTH-1:0] w_pend;
  logic [DEPTH-1:0] w_pend_d;
  logic [DEPTH-1:0] w_wr_dec;
  logic [DEPTH-1:0] w_iss_dec;

  // Register 0 is excluded from both decoders, so it never stores or goes busy.
  always_comb begin
    w_wr_dec  = '0;
    w_iss_dec = '0;
    for (int r = 1; r < int'(DEPTH); r++) begin
      w_wr_dec[r]  = i_reg_write && (i_write_reg == ADDR_W'(r));
      w_iss_dec[r] = i_issue_valid && (i_issue_reg == ADDR_W'(r));
    end
  end

  // Flush beats issue; issue beats a same-cycle writeback clear.
  always_comb begin
    w_pend_d = w_pend;
    if (i_flush) begin
      w_pend_d = '0;
    end else begin
      for (int r = 1; r < int'(DEPTH); r++) begin
        if (w_iss_dec[r]) begin
          w_pend_d[r] = 1'b1;
        end else if (w_wr_dec[r]) begin
          w_pend_d[r] = 1'b0;
        end
      end
    end
  end

  assign w_regs[0] = '0;
  assign w_pend[0] = 1'b0;

  for (genvar g = 1; g < int'(DEPTH); g++) begin : g_reg
    logic [N-1:0] r_data;
    logic         r_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_data <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_wr_dec[g]) begin
          r_data <= i_write_data;
        end
        r_pend <= w_pend_d[g];
      end
    end

    assign w_regs[g] = r_data;
    assign w_pend[g] = r_pend;
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;

    assign w_addr = i_read_reg[k*ADDR_W +: ADDR_W];
    // Reset gates the bypass so outputs stay zero while reset is held.
    assign w_hit  = (BYPASS != 0) && i_rst_n && i_reg_write &&
                    (i_write_reg == w_addr) && (w_addr != '0);

    assign o_read_data[k*N +: N] = w_hit ? i_write_data : w_regs[w_addr];
    assign o_read_busy[k]        = w_hit ? 1'b0 : w_pend[w_addr];
  end

  assign o_any_busy = |w_pend;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomized bench for regfile_mp_scoreboard: three configurations checked every
// cycle against an array-based model, plus directed literal checks.
module tb_regfile_mp_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default config (bypass on) and a bypass-off twin share this stimulus.
  logic [9:0]  rr;
  logic        rw;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        iv;
  logic [4:0]  ir;
  logic        fl;
  logic [63:0] rd_b1, rd_b0;
  logic [1:0]  bz_b1, bz_b0;
  logic        any_b1, any_b0;

  // Wide config: N=64, DEPTH=16, NUM_RD=4.
  logic [15:0]  p_rr;
  logic         p_rw;
  logic [3:0]   p_wr;
  logic [63:0]  p_wd;
  logic         p_iv;
  logic [3:0]   p_ir;
  logic         p_fl;
  logic [255:0] p_rd;
  logic [3:0]   p_bz;
  logic         p_any;

  int n_chk = 0;
  int n_err = 0;

  regfile_mp_scoreboard #(.N(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) dut_b1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_reg(rr), .o_read_data(rd_b1),
    .o_read_busy(bz_b1), .i_reg_write(rw), .i_write_reg(wr), .i_write_data(wd),
    .i_issue_valid(iv), .i_issue_reg(ir), .i_flush(fl), .o_any_busy(any_b1)
  );

  regfile_mp_scoreboard #(.N(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) dut_b0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_reg(rr), .o_read_data(rd_b0),
    .o_read_busy(bz_b0), .i_reg_write(rw), .i_write_reg(wr), .i_write_data(wd),
    .i_issue_valid(iv), .i_issue_reg(ir), .i_flush(fl), .o_any_busy(any_b0)
  );

  regfile_mp_scoreboard #(.N(64), .DEPTH(16), .NUM_RD(4), .BYPASS(1)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_reg(p_rr), .o_read_data(p_rd),
    .o_read_busy(p_bz), .i_reg_write(p_rw), .i_write_reg(p_wr), .i_write_data(p_wd),
    .i_issue_valid(p_iv), .i_issue_reg(p_ir), .i_flush(p_fl), .o_any_busy(p_any)
  );

  // Behavioural model: stored values and pending flags as plain arrays.
  logic [31:0] m_reg [32];
  logic [31:0] m_pend;
  logic [63:0] mp_reg [16];
  logic [15:0] mp_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      for (int i = 0; i < 16; i++) mp_reg[i] = '0;
      m_pend  = '0;
      mp_pend = '0;
    end else begin
      if (rw && wr != 0) m_reg[wr] = wd;
      if (fl) m_pend = '0;
      else begin
        if (rw && wr != 0) m_pend[wr] = 1'b0;
        if (iv && ir != 0) m_pend[ir] = 1'b1;
      end
      if (p_rw && p_wr != 0) mp_reg[p_wr] = p_wd;
      if (p_fl) mp_pend = '0;
      else begin
        if (p_rw && p_wr != 0) mp_pend[p_wr] = 1'b0;
        if (p_iv && p_ir != 0) mp_pend[p_ir] = 1'b1;
      end
    end
  end

  function automatic logic [63:0] e_data(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return '0;
    if (byp && rw && wr == a) return {32'd0, wd};
    return {32'd0, m_reg[a]};
  endfunction

  function automatic logic e_busy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && rw && wr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [63:0] ep_data(input logic [3:0] a);
    if (!rst_n || a == 0) return '0;
    if (p_rw && p_wr == a) return p_wd;
    return mp_reg[a];
  endfunction

  function automatic logic ep_busy(input logic [3:0] a);
    if (!rst_n || a == 0) return 1'b0;
    if (p_rw && p_wr == a) return 1'b0;
    return mp_pend[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("b1_data%0d", k), {32'd0, rd_b1[k*32 +: 32]}, e_data(rr[k*5 +: 5], 1'b1));
      chk($sformatf("b1_busy%0d", k), {63'd0, bz_b1[k]}, {63'd0, e_busy(rr[k*5 +: 5], 1'b1)});
      chk($sformatf("b0_data%0d", k), {32'd0, rd_b0[k*32 +: 32]}, e_data(rr[k*5 +: 5], 1'b0));
      chk($sformatf("b0_busy%0d", k), {63'd0, bz_b0[k]}, {63'd0, e_busy(rr[k*5 +: 5], 1'b0)});
    end
    chk("b1_any", {63'd0, any_b1}, {63'd0, rst_n && (m_pend != 0)});
    chk("b0_any", {63'd0, any_b0}, {63'd0, rst_n && (m_pend != 0)});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("p_data%0d", k), p_rd[k*64 +: 64], ep_data(p_rr[k*4 +: 4]));
      chk($sformatf("p_busy%0d", k), {63'd0, p_bz[k]}, {63'd0, ep_busy(p_rr[k*4 +: 4])});
    end
    chk("p_any", {63'd0, p_any}, {63'd0, rst_n && (mp_pend != 0)});
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr = '0; rw = 0; wr = '0; wd = '0; iv = 0; ir = '0; fl = 0;
    p_rr = '0; p_rw = 0; p_wr = '0; p_wd = '0; p_iv = 0; p_ir = '0; p_fl = 0;
    next(); next();
    chk("rst_any", {63'd0, any_b1}, 64'd0);
    chk("rst_data0", rd_b1[63:0], 64'd0);
    rst_n = 1;

    // Wide config: four independent ports.
    next(); p_rw = 1; p_wr = 4'd1;  p_wd = 64'h1111_2222_3333_4444;
    next(); p_wr = 4'd2;  p_wd = 64'h5555_6666_7777_8888;
    next(); p_wr = 4'd15; p_wd = 64'h9999_AAAA_BBBB_CCCC;
    next(); p_wr = 4'd0;  p_wd = 64'hFFFF_FFFF_FFFF_FFFF;
    next(); p_rw = 0; p_rr = {4'd0, 4'd15, 4'd2, 4'd1};
    #1;
    chk("p_port0", p_rd[63:0],    64'h1111_2222_3333_4444);
    chk("p_port1", p_rd[127:64],  64'h5555_6666_7777_8888);
    chk("p_port2", p_rd[191:128], 64'h9999_AAAA_BBBB_CCCC);
    chk("p_port3", p_rd[255:192], 64'd0);

    // Write then read on both ports; write to r0 is dropped.
    next(); rw = 1; wr = 5'd3; wd = 32'h1234_5678;
    next(); rw = 0; rr = {5'd3, 5'd3};
    #1;
    chk("wr_rd_p0", {32'd0, rd_b1[31:0]},  64'h1234_5678);
    chk("wr_rd_p1", {32'd0, rd_b1[63:32]}, 64'h1234_5678);
    chk("nb_wr_rd", {32'd0, rd_b0[31:0]},  64'h1234_5678);
    next(); rw = 1; wr = 5'd0; wd = 32'hFFFF_FFFF; rr = '0;
    next(); rw = 0;
    #1;
    chk("r0_zero", {32'd0, rd_b1[31:0]}, 64'd0);

    // Bypass versus no bypass with reg7 pending.
    next(); rw = 1; wr = 5'd7; wd = 32'h11;
    next(); rw = 0; iv = 1; ir = 5'd7;
    next(); iv = 0; rw = 1; wr = 5'd7; wd = 32'hA5A5_A5A5; rr = {5'd0, 5'd7};
    #1;
    chk("byp_data", {32'd0, rd_b1[31:0]}, 64'hA5A5_A5A5);
    chk("byp_busy", {63'd0, bz_b1[0]}, 64'd0);
    chk("nobyp_data", {32'd0, rd_b0[31:0]}, 64'h11);
    chk("nobyp_busy", {63'd0, bz_b0[0]}, 64'd1);
    next(); rw = 0;
    #1;
    chk("nobyp_after", {32'd0, rd_b0[31:0]}, 64'hA5A5_A5A5);

    // Scoreboard set and clear.
    next(); iv = 1; ir = 5'd9;
    next(); iv = 0; rr = {5'd0, 5'd9};
    #1;
    chk("sb_busy", {63'd0, bz_b1[0]}, 64'd1);
    chk("sb_any", {63'd0, any_b1}, 64'd1);
    next(); rw = 1; wr = 5'd9; wd = 32'h99;
    next(); rw = 0;
    #1;
    chk("sb_clear", {63'd0, bz_b0[0]}, 64'd0);
    chk("sb_any_clr", {63'd0, any_b0}, 64'd0);

    // Issue/write collision, then flush overriding issue.
    next(); iv = 1; ir = 5'd4; rw = 1; wr = 5'd4; wd = 32'h44;
    next(); iv = 0; rw = 0; rr = {5'd6, 5'd4};
    #1;
    chk("coll_busy", {63'd0, bz_b1[0]}, 64'd1);
    next(); fl = 1; iv = 1; ir = 5'd6;
    next(); fl = 0; iv = 0;
    #1;
    chk("flush_b4", {63'd0, bz_b1[0]}, 64'd0);
    chk("flush_b6", {63'd0, bz_b1[1]}, 64'd0);
    chk("flush_any", {63'd0, any_b1}, 64'd0);

    // Asynchronous reset mid-run.
    next(); rw = 1; wr = 5'd5; wd = 32'hDEAD_BEEF;
    next(); rw = 0; rr = {5'd0, 5'd5};
    #1;
    chk("pre_rst", {32'd0, rd_b1[31:0]}, 64'hDEAD_BEEF);
    next(); rst_n = 0; iv = 1; ir = 5'd3;
    #1;
    chk("in_rst_data", {32'd0, rd_b1[31:0]}, 64'd0);
    chk("in_rst_any", {63'd0, any_b1}, 64'd0);
    next(); next(); rst_n = 1; iv = 0;
    #1;
    chk("post_rst_r5", {32'd0, rd_b1[31:0]}, 64'd0);
    chk("post_rst_busy", {63'd0, bz_b1[1]}, 64'd0);

    // Randomized traffic on all three configurations.
    for (int c = 0; c < 4000; c++) begin
      next();
      rst_n = ($urandom_range(0, 299) != 0);
      rw = ($urandom_range(0, 9) < 4);
      wr = 5'($urandom_range(0, 31));
      wd = $urandom;
      iv = ($urandom_range(0, 1) == 0);
      ir = 5'($urandom_range(0, 31));
      fl = ($urandom_range(0, 39) == 0);
      rr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) rr[4:0] = wr;
      p_rw = ($urandom_range(0, 9) < 4);
      p_wr = 4'($urandom_range(0, 15));
      p_wd = {$urandom, $urandom};
      p_iv = ($urandom_range(0, 1) == 0);
      p_ir = 4'($urandom_range(0, 15));
      p_fl = ($urandom_range(0, 39) == 0);
      p_rr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) p_rr[7:4] = p_wr;
    end

    next();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
